// File: rtl/idp_sequencer.sv
// Multi-cycle control sequencer for the integer datapath: walks one MIPS instruction
// through DECODE, EXEC, optional MEM and write-back, with registered Moore outputs.
module idp_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        D_En,
    output logic        HILO_ld,
    output logic [1:0]  DA_Sel,
    output logic        T_Sel,
    output logic        ze_sel,
    output logic [2:0]  Y_Sel,
    output logic [4:0]  FS,
    output logic        done,
    output logic        illegal
);
    localparam logic [4:0] FS_PASS = 5'h00, FS_ADD = 5'h02, FS_ADDU = 5'h03, FS_SUB = 5'h04,
                           FS_SUBU = 5'h05, FS_SLT = 5'h06, FS_SLTU = 5'h07, FS_AND = 5'h08,
                           FS_OR = 5'h09, FS_XOR = 5'h0A, FS_NOR = 5'h0B, FS_SLL = 5'h0C,
                           FS_SRL = 5'h0D, FS_SRA = 5'h0E, FS_LUI = 5'h16, FS_MUL = 5'h1E,
                           FS_DIV = 5'h1F;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_LDWB, S_WB} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  opcode_reg, opcode_next;
    logic [5:0]  funct_reg, funct_next;
    logic        accept;

    // Only opcode and funct steer control; the register fields go straight to the datapath.
    logic instr_unused;
    assign instr_unused = ^instr[25:6];

    logic        dec_legal, dec_itype, dec_ze, dec_load, dec_store, dec_hilo;
    logic [4:0]  dec_fs;
    logic [2:0]  dec_ysel;

    logic        ready_next, req_next, we_next, den_next, hilo_next;
    logic        tsel_next, ze_next, done_next, illegal_next;
    logic [1:0]  dasel_next;
    logic [2:0]  ysel_next;
    logic [4:0]  fs_next;

    assign accept      = (state_reg == S_IDLE) && instr_valid;
    assign opcode_next = accept ? instr[31:26] : opcode_reg;
    assign funct_next  = accept ? instr[5:0]   : funct_reg;

    // Decoding the next instruction lets every output be registered with no extra latency.
    always_comb begin
        dec_legal = 1'b1;
        dec_itype = 1'b0;
        dec_ze    = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_hilo  = 1'b0;
        dec_fs    = FS_PASS;
        dec_ysel  = 3'd0;
        if (opcode_next == 6'h00) begin
            case (funct_next)
                6'h20: dec_fs = FS_ADD;
                6'h21: dec_fs = FS_ADDU;
                6'h22: dec_fs = FS_SUB;
                6'h23: dec_fs = FS_SUBU;
                6'h24: dec_fs = FS_AND;
                6'h25: dec_fs = FS_OR;
                6'h26: dec_fs = FS_XOR;
                6'h27: dec_fs = FS_NOR;
                6'h2A: dec_fs = FS_SLT;
                6'h2B: dec_fs = FS_SLTU;
                6'h00: dec_fs = FS_SLL;
                6'h02: dec_fs = FS_SRL;
                6'h03: dec_fs = FS_SRA;
                6'h18: begin dec_fs = FS_MUL; dec_hilo = 1'b1; end
                6'h1A: begin dec_fs = FS_DIV; dec_hilo = 1'b1; end
                6'h10: dec_ysel = 3'd1;
                6'h12: dec_ysel = 3'd2;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            dec_itype = 1'b1;
            case (opcode_next)
                6'h08: dec_fs = FS_ADD;
                6'h09: dec_fs = FS_ADDU;
                6'h0C: begin dec_fs = FS_AND; dec_ze = 1'b1; end
                6'h0D: begin dec_fs = FS_OR;  dec_ze = 1'b1; end
                6'h0F: dec_fs = FS_LUI;
                6'h23: begin dec_fs = FS_ADD; dec_load = 1'b1; end
                6'h2B: begin dec_fs = FS_ADD; dec_store = 1'b1; end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = dec_legal ? S_EXEC : S_IDLE;
            S_EXEC:   state_next = (dec_load || dec_store) ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) state_next = dec_store ? S_WB : S_LDWB;
            S_LDWB:   state_next = S_IDLE;
            S_WB:     state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_next   = 1'b0;
        req_next     = 1'b0;
        we_next      = 1'b0;
        den_next     = 1'b0;
        hilo_next    = 1'b0;
        dasel_next   = 2'd0;
        tsel_next    = 1'b0;
        ze_next      = 1'b0;
        ysel_next    = 3'd0;
        fs_next      = 5'd0;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        if (state_next != S_IDLE && dec_legal) begin
            fs_next   = dec_fs;
            tsel_next = dec_itype;
            ze_next   = dec_ze;
        end
        case (state_next)
            S_IDLE:   ready_next = 1'b1;
            S_DECODE: if (!dec_legal) begin
                done_next    = 1'b1;
                illegal_next = 1'b1;
            end
            S_EXEC:   hilo_next = dec_hilo;
            S_MEM: begin
                req_next = 1'b1;
                we_next  = dec_store;
            end
            S_LDWB: begin
                ysel_next  = 3'd3;
                dasel_next = 2'd1;
                den_next   = 1'b1;
                done_next  = 1'b1;
            end
            S_WB: begin
                done_next  = 1'b1;
                den_next   = !(dec_hilo || dec_store);
                ysel_next  = dec_ysel;
                dasel_next = dec_itype ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            opcode_reg  <= 6'd0;
            funct_reg   <= 6'd0;
            instr_ready <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            D_En        <= 1'b0;
            HILO_ld     <= 1'b0;
            DA_Sel      <= 2'd0;
            T_Sel       <= 1'b0;
            ze_sel      <= 1'b0;
            Y_Sel       <= 3'd0;
            FS          <= 5'd0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            opcode_reg  <= opcode_next;
            funct_reg   <= funct_next;
            instr_ready <= ready_next;
            mem_req     <= req_next;
            mem_we      <= we_next;
            D_En        <= den_next;
            HILO_ld     <= hilo_next;
            DA_Sel      <= dasel_next;
            T_Sel       <= tsel_next;
            ze_sel      <= ze_next;
            Y_Sel       <= ysel_next;
            FS          <= fs_next;
            done        <= done_next;
            illegal     <= illegal_next;
        end
    end
endmodule

// File: tb/tb_idp_sequencer.sv
// Bench for idp_sequencer: randomized instructions and ack delays, each expanded by a
// reference model into a per-cycle schedule of expected control outputs.
module tb_idp_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_ack = 1'b0;
    logic        instr_ready, mem_req, mem_we, D_En, HILO_ld, T_Sel, ze_sel, done, illegal;
    logic [1:0]  DA_Sel;
    logic [2:0]  Y_Sel;
    logic [4:0]  FS;

    idp_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .D_En(D_En), .HILO_ld(HILO_ld), .DA_Sel(DA_Sel), .T_Sel(T_Sel), .ze_sel(ze_sel),
        .Y_Sel(Y_Sel), .FS(FS), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] RESET_VEC = 19'h40000;

    int checks = 0;
    int errors = 0;

    int r_fs[int];
    int i_fs[int];
    int fn_list[17] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A,
                        32'h2B, 32'h00, 32'h02, 32'h03, 32'h18, 32'h1A, 32'h10, 32'h12};
    int op_list[7]  = '{32'h08, 32'h09, 32'h0C, 32'h0D, 32'h0F, 32'h23, 32'h2B};

    logic [18:0] exp_q[$];
    bit          ack_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] pack(bit rdy, bit req, bit we, bit den, bit hl, int da,
                                         bit ts, bit ze, int ys, int fs, bit dn, bit il);
        return {rdy, req, we, den, hl, 2'(da), ts, ze, 3'(ys), 5'(fs), dn, il};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {instr_ready, mem_req, mem_we, D_En, HILO_ld, DA_Sel, T_Sel, ze_sel,
                Y_Sel, FS, done, illegal};
    endfunction

    // Expected outputs for each cycle after acceptance, plus the ack to drive in that cycle.
    task automatic build(input logic [31:0] w, input int n);
        int  op, fn, fs, ysel;
        bit  legal, itype, ze, ld, st, hl;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        exp_q.delete();
        ack_q.delete();
        itype = (op != 0);
        if (!itype) begin
            legal = r_fs.exists(fn);
            fs    = legal ? r_fs[fn] : 0;
        end else begin
            legal = i_fs.exists(op);
            fs    = legal ? i_fs[op] : 0;
        end
        ze   = (op == 'h0C) || (op == 'h0D);
        ld   = (op == 'h23);
        st   = (op == 'h2B);
        hl   = !itype && (fn == 'h18 || fn == 'h1A);
        ysel = (!itype && fn == 'h10) ? 1 : (!itype && fn == 'h12) ? 2 : 0;
        if (!legal) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
            ack_q.push_back(bit'($urandom_range(0, 1)));
        end else begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, itype, ze, 0, fs, 0, 0));
            ack_q.push_back(bit'($urandom_range(0, 1)));
            exp_q.push_back(pack(0, 0, 0, 0, hl, 0, itype, ze, 0, fs, 0, 0));
            ack_q.push_back(bit'($urandom_range(0, 1)));
            if (ld || st) begin
                for (int j = 0; j <= n; j++) begin
                    exp_q.push_back(pack(0, 1, st, 0, 0, 0, itype, ze, 0, fs, 0, 0));
                    ack_q.push_back(j == n);
                end
                if (ld) exp_q.push_back(pack(0, 0, 0, 1, 0, 1, itype, ze, 3, fs, 1, 0));
                else    exp_q.push_back(pack(0, 0, 0, 0, 0, 1, itype, ze, 0, fs, 1, 0));
            end else begin
                exp_q.push_back(pack(0, 0, 0, !hl, 0, itype ? 1 : 0, itype, ze, ysel, fs, 1, 0));
            end
            ack_q.push_back(bit'($urandom_range(0, 1)));
        end
        exp_q.push_back(RESET_VEC);
        ack_q.push_back(1'b0);
    endtask

    task automatic run_instr(input logic [31:0] w, input int n);
        build(w, n);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = w;
        mem_ack     = bit'($urandom_range(0, 1));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                instr_valid = bit'($urandom_range(0, 1));
                instr       = $urandom;
                mem_ack     = ack_q[k-1];
            end
            @(posedge clk);
            #1;
            check_eq($sformatf("instr %08h ack_delay %0d cycle %0d", w, n, k + 1),
                     32'(obs_vec()), 32'(exp_q[k]));
        end
    endtask

    task automatic idle_gap(input int cycles);
        for (int g = 0; g < cycles; g++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ack     = bit'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_eq("idle", 32'(obs_vec()), 32'(RESET_VEC));
        end
    endtask

    // Abort a load in MEM: outputs must drop without waiting for a clock edge.
    task automatic reset_during_mem();
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 32'h8C250008;
        mem_ack     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                instr_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check_eq("mem_req before reset", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1 check_eq("async reset in MEM", 32'(obs_vec()), 32'(RESET_VEC));
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1 check_eq("held reset, no done", 32'(obs_vec()), 32'(RESET_VEC));
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1 check_eq("idle after reset", 32'(obs_vec()), 32'(RESET_VEC));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 5) begin
            w[31:26] = 6'd0;
            w[5:0]   = 6'(fn_list[$urandom_range(0, 16)]);
        end else if (sel < 9) begin
            w[31:26] = 6'(op_list[$urandom_range(0, 6)]);
        end
        return w;
    endfunction

    initial begin
        r_fs['h20] = 'h02; r_fs['h21] = 'h03; r_fs['h22] = 'h04; r_fs['h23] = 'h05;
        r_fs['h24] = 'h08; r_fs['h25] = 'h09; r_fs['h26] = 'h0A; r_fs['h27] = 'h0B;
        r_fs['h2A] = 'h06; r_fs['h2B] = 'h07; r_fs['h00] = 'h0C; r_fs['h02] = 'h0D;
        r_fs['h03] = 'h0E; r_fs['h18] = 'h1E; r_fs['h1A] = 'h1F; r_fs['h10] = 'h00;
        r_fs['h12] = 'h00;
        i_fs['h08] = 'h02; i_fs['h09] = 'h03; i_fs['h0C] = 'h08; i_fs['h0D] = 'h09;
        i_fs['h0F] = 'h16; i_fs['h23] = 'h02; i_fs['h2B] = 'h02;

        #2 reset = 1'b1;
        #2 check_eq("reset async", 32'(obs_vec()), 32'(RESET_VEC));
        repeat (2) @(posedge clk);
        #1 check_eq("reset held", 32'(obs_vec()), 32'(RESET_VEC));
        @(negedge clk);
        reset = 1'b0;

        run_instr(32'h00221820, 0);
        run_instr(32'h00220018, 0);
        run_instr(32'h00002012, 0);
        run_instr(32'h8C250008, 3);
        run_instr(32'h3406FFFF, 0);
        run_instr(32'hAC250004, 0);
        run_instr(32'hFC000000, 0);
        reset_during_mem();
        run_instr(32'h00221820, 0);

        for (int t = 0; t < 300; t++) begin
            run_instr(rand_word(), $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/idp_sequencer.md
# idp_sequencer

Multi-cycle control sequencer for the integer datapath: accepts one 32-bit MIPS instruction per handshake and steps it through decode, execute, optional memory and write-back. In each state it drives the datapath's register-file enables, mux selects and ALU function select, and runs a request/acknowledge exchange with data memory. It sits between the instruction unit and the integer datapath and replaces hand-driven control words in the lab tests.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high. Forces IDLE and all outputs to their reset values.
- instr_valid  in  1  instruction unit presents instr.
- instr  in  32  MIPS instruction word.
- instr_ready  out  1  high only in IDLE. Reset value 1.
- mem_ack  in  1  data memory completed the current access.
- mem_req, mem_we  out  1 each  memory request / write qualifier. Reset value 0.
- D_En, HILO_ld  out  1 each  register-file / HI-LO load enables. Reset value 0.
- DA_Sel  out  2  0=rd, 1=rt, 2=$ra, 3=$sp. Reset value 0.
- T_Sel  out  1  1 selects immediate DT into RT. Reset value 0.
- ze_sel  out  1  instruction unit zero-extends (1) vs sign-extends (0) the immediate. Reset value 0.
- Y_Sel  out  3  0=alu_out, 1=hi, 2=lo, 3=d_in, 4=pc_in. Reset value 0.
- FS  out  5  ALU function select. Reset value 0.
- done  out  1  one-cycle pulse when the instruction retires. Reset value 0.
- illegal  out  1  one-cycle pulse on an unsupported encoding. Reset value 0.

## Operation
- FS encoding (fixed):
  - PASS_S 00
  - ADD 02, ADDU 03, SUB 04, SUBU 05
  - SLT 06, SLTU 07
  - AND 08, OR 09, XOR 0A, NOR 0B
  - SLL 0C, SRL 0D, SRA 0E
  - LUI 16
  - MUL 1E, DIV 1F
- Supported instructions:
  - R-type (funct): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, mult, div, mfhi, mflo.
  - I-type: addi (ADD), addiu (ADDU), andi/ori (AND/OR, ze_sel=1), lui (LUI), lw/sw (ADD address).
  - Everything else is illegal.
- States: IDLE, DECODE, EXEC, MEM, LDWB, WB. All outputs are registered (Moore), decoded from state plus the latched instruction.
- IDLE
  - instr_ready=1.
  - If instr_valid is high, latch instr and go to DECODE.
- DECODE
  - Set T_Sel=1 for I-types and ze_sel per opcode; RS/RT capture at the end of the cycle.
  - Illegal encoding: pulse illegal and done, return to IDLE with no enables asserted.
- EXEC
  - Drive FS. ALU_out captures at the end of the cycle.
  - mult/div: HILO_ld=1 for exactly this cycle.
  - lw/sw go to MEM; all others go to WB.
- MEM
  - mem_req=1; mem_we=1 for sw. Y_Sel=0, so the address appears on ALU_OUT and the store data on D_OUT.
  - Hold until mem_ack is sampled high.
  - On ack: sw goes to WB; lw goes to LDWB, where d_in captures DY.
- LDWB
  - Y_Sel=3, DA_Sel=1, D_En=1.
  - Pulse done, go to IDLE.
- WB
  - Pulse done, go to IDLE.
  - D_En=1 except for mult, div and sw.
  - Y_Sel: mfhi=1, mflo=2, otherwise 0.
  - DA_Sel: R-type=0, I-type=1.
- FS, T_Sel and ze_sel hold their decoded values from DECODE through WB. All other enables are 0 outside the states listed above.

## Timing
- Instruction accepted at edge 0 (IDLE, valid high).
- ALU, mfhi, mflo, mult, div: DECODE in cycle 1, EXEC in cycle 2, WB/done in cycle 3. The next accept is at the end of cycle 4 (IDLE for one cycle).
- Memory: MEM begins in cycle 3 and lasts N+1 cycles for an ack N cycles after mem_req rises; LDWB or WB follows.
- Illegal: illegal and done pulse in cycle 1.
- mem_ack is ignored outside MEM. An ack coincident with the first MEM cycle completes MEM in one cycle.
- instr_valid is ignored outside IDLE; instr is sampled only at acceptance.
- Reset asserted mid-instruction aborts it: outputs drop asynchronously to reset values, and no done or write-enable pulse occurs.

## Test plan
- Reset with all inputs 0 -> instr_ready=1, every other output 0, state IDLE.
- Issue `add $3,$1,$2` (0x00221820) -> cycle 1 T_Sel=0, cycle 2 FS=02, cycle 3 D_En=1, DA_Sel=0, Y_Sel=0, done=1; D_En is high for exactly one cycle.
- Issue `mult $1,$2` (0x00220018) then `mflo $4` (0x00002012) back-to-back:
  - mult: HILO_ld=1 in EXEC with FS=1E, and no D_En.
  - mflo: WB shows Y_Sel=2, D_En=1.
- Issue `lw $5,8($1)` (0x8C250008) with mem_ack delayed 3 cycles:
  - mem_req high 4 cycles, mem_we=0.
  - LDWB: Y_Sel=3, DA_Sel=1, D_En=1, done=1.
- Issue `ori $6,$0,0xFFFF` (0x3406FFFF) -> T_Sel=1, ze_sel=1, FS=09, DA_Sel=1 in WB. Then `sw` with immediate ack -> mem_we=1 for one cycle, no D_En.
- Issue opcode 0x3F -> illegal and done pulse in cycle 1. Separately, reset asserted during MEM -> mem_req falls immediately with no done pulse; a new instruction is accepted after reset is released.
